fp_seq_div: RTL and testbench
=============================

// Module: fp_seq_div
// PURPOSE
//  Sequential IEEE-754 single-precision divider: result = a / b, one quotient bit per clock.
//  Restoring division of 24-bit mantissas plus exponent subtraction. Fixed latency, start/done handshake.
//  Inverse companion of the sequential FP multiplier; shares its operand format and flush-to-zero rules.
// PARAMETERS
//  EXP_W   8    exponent width
//  FRAC_W  23   stored fraction width; mantissa = {1'b1, frac}
//  QW      26   quotient bits produced (FRAC_W+3); iteration count
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   synchronous reset, active-high
//  start       in   1   request; sampled only when busy=0
//  a           in   32  dividend, IEEE single
//  b           in   32  divisor, IEEE single
//  busy        out  1   operation in flight
//  done        out  1   one-cycle pulse; result and flags valid
//  result      out  32  quotient, IEEE single
//  overflow    out  1   exponent >= 255; result = signed inf
//  underflow   out  1   exponent <= 0; result = signed zero
//  div_by_zero out  1   b exponent == 0
// BEHAVIOUR
//  Reset: busy=0, done=0, result=0, overflow=0, underflow=0, div_by_zero=0, FSM=IDLE. Applies mid-operation: job dropped, no done.
//  FSM IDLE->LOAD->DIV(QW cycles)->NORM->IDLE.
//  - IDLE: start && !busy latches a, b.
//  - LOAD: R=ma, signed 10-bit e = ea - eb + 127.
//  - DIV: if R>=mb then q=1, R=R-mb; R=R<<1; q shifts into Q[QW-1:0].
//  - NORM: normalise; pulse done.
//  Latency: start accepted at edge k -> busy=1 from k+1 -> done=1 for exactly the cycle after edge k+28 (QW+2). busy drops with done.
//  start while busy: ignored, no queuing. result and flags hold from done until the next done or rst.
//  Normalise:
//  - Q[25]=1: frac=Q[24:2], exp=e.
//  - Q[25]=0: frac=Q[23:1], exp=e-1.
//  sign = sa ^ sb.
//  Specials: still run the full latency; the result is overridden in NORM.
//  - ea==0: a is zero (denormals flushed); result = {sign, 31'b0}.
//  - eb==0: div_by_zero=1, result = {sign, 8'hFF, 23'b0}.
//  - ea==0 && eb==0: result = 32'h7FC00000, div_by_zero=1.
//  - exp>=255: overflow=1, result = signed inf.
//  - exp<=0: underflow=1, result = signed zero.
//  - Priority: zero/zero > div-by-zero > zero dividend > overflow > underflow.
//  - Exponent 255 inputs get no special handling (same as the multiplier).
//  All flags are 0 on a normal result.
// CONFIGURATION
//  FP_DIV_ROUND_EN defined: round-to-nearest-even.
//  - guard = bit below the kept LSB (Q[1] or Q[0]).
//  - sticky = lower Q bits | (R!=0).
//  - Increment when guard & (sticky | lsb). Fraction carry-out increments exp; overflow is checked after rounding.
//  Undefined: truncation (round toward zero); guard/sticky logic absent.
// STRUCTURE
//  fp_pkg: EXP_W, FRAC_W, BIAS=127, QNAN=32'h7FC00000, POS_INF, typedef fp32_t (packed sign/exp/frac).
//  Sub-module mant_restoring_div: unsigned iterative core.
//  - Inputs: clk, rst, load, dividend, divisor.
//  - Outputs: quotient[QW-1:0], rem_nz.
//  fp_seq_div holds the FSM, exponent/sign path, special-case override and rounding.
// TESTING
//  1 a=40C00000 (6.0), b=40000000 (2.0) -> result 40400000; done exactly 28 cycles after start; flags 0.
//  2 a=3F800000, b=40400000 (1/3) -> 3EAAAAAA without FP_DIV_ROUND_EN; 3EAAAAAB with it.
//  3 a=C1000000 (-8), b=3F000000 (0.5) -> C1800000. Then a=3F800000, b=0 -> 7F800000, div_by_zero=1, overflow=0.
//    Then a=0, b=0 -> 7FC00000.
//  4 a=7F000000, b=00800000 -> overflow=1, result 7F800000.
//    a=00800000, b=40000000 -> underflow=1, result 00000000.
//  5 start pulsed again at cycle 5 with new operands -> ignored; first result still correct, single done.
//  6 rst at cycle 10 of an operation -> next cycle busy=0, outputs 0, no done; a new start gives the correct result after 28 cycles.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, operand format and FSM encoding for the sequential FP divider.
package fp_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = FRAC_W + 1;
  localparam int unsigned QW     = FRAC_W + 3;
  localparam int unsigned RW     = MANT_W + 2;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV,
    ST_NORM
  } state_t;

endpackage

// File: rtl/mant_restoring_div.sv
// Unsigned restoring mantissa divider: one quotient bit per clock after load.
module mant_restoring_div
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [MANT_W-1:0] dividend,
  input  logic [MANT_W-1:0] divisor,
  output logic [QW-1:0]     quotient,
  output logic              rem_nz
);

  logic [RW-1:0]     rem_q, rem_d, diff;
  logic [MANT_W-1:0] div_q, div_d;
  logic [QW-1:0]     quo_q, quo_d;

  // Trial subtract; keep the difference only when it does not go negative.
  always_comb begin
    rem_d = rem_q;
    div_d = div_q;
    quo_d = quo_q;
    diff  = rem_q - RW'(div_q);
    if (load) begin
      rem_d = RW'(dividend);
      div_d = divisor;
      quo_d = '0;
    end else if (rem_q >= RW'(div_q)) begin
      rem_d = {diff[RW-2:0], 1'b0};
      quo_d = {quo_q[QW-2:0], 1'b1};
    end else begin
      rem_d = {rem_q[RW-2:0], 1'b0};
      quo_d = {quo_q[QW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
    end else begin
      rem_q <= rem_d;
      div_q <= div_d;
      quo_q <= quo_d;
    end
  end

  assign quotient = quo_q;
  assign rem_nz   = |rem_q;

endmodule

// File: rtl/fp_seq_div.sv
// Sequential IEEE-754 single-precision divider, fixed 28-cycle latency.
// Optional round-to-nearest-even when FP_DIV_ROUND_EN is defined; truncation otherwise.
module fp_seq_div
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  fp32_t              a_q, a_d, b_q, b_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic               ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d;

  logic               core_load;
  logic [QW-1:0]      quo;
  logic               rem_nz;

  logic               sign_n;
  logic signed [9:0]  exp_n;
  logic [FRAC_W-1:0]  frac_n;
  logic [31:0]        norm_result;
  logic               norm_ovf, norm_unf, norm_dbz;

  mant_restoring_div u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .dividend ({1'b1, a_q.frac}),
    .divisor  ({1'b1, b_q.frac}),
    .quotient (quo),
    .rem_nz   (rem_nz)
  );

  // Normalise, round and apply special-case overrides.
  always_comb begin
    sign_n      = a_q.sign ^ b_q.sign;
    exp_n       = exp_q;
    frac_n      = quo[QW-2:2];
    norm_ovf    = 1'b0;
    norm_unf    = 1'b0;
    norm_dbz    = 1'b0;
    if (!quo[QW-1]) begin
      exp_n  = exp_q - 10'sd1;
      frac_n = quo[QW-3:1];
    end
`ifdef FP_DIV_ROUND_EN
    begin
      logic              guard, sticky, carry;
      logic [FRAC_W-1:0] frac_r;
      guard  = quo[QW-1] ? quo[1] : quo[0];
      sticky = quo[QW-1] ? (quo[0] | rem_nz) : rem_nz;
      {carry, frac_r} = {1'b0, frac_n} + (FRAC_W+1)'(1);
      if (guard && (sticky || frac_n[0])) begin
        frac_n = frac_r;
        if (carry) exp_n = exp_n + 10'sd1;
      end
    end
`endif
    norm_result = {sign_n, exp_n[EXP_W-1:0], frac_n};
    if (a_q.exp == '0 && b_q.exp == '0) begin
      norm_result = QNAN;
      norm_dbz    = 1'b1;
    end else if (b_q.exp == '0) begin
      norm_result = POS_INF | {sign_n, 31'b0};
      norm_dbz    = 1'b1;
    end else if (a_q.exp == '0) begin
      norm_result = {sign_n, 31'b0};
    end else if (exp_n >= 10'sd255) begin
      norm_result = POS_INF | {sign_n, 31'b0};
      norm_ovf    = 1'b1;
    end else if (exp_n <= 10'sd0) begin
      norm_result = {sign_n, 31'b0};
      norm_unf    = 1'b1;
    end
  end

`ifndef FP_DIV_ROUND_EN
  logic unused_trunc;
  assign unused_trunc = ^{quo[0], rem_nz};
`endif

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    exp_d     = exp_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    dbz_d     = dbz_q;
    core_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !busy_q) begin
          a_d     = a;
          b_d     = b;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        core_load = 1'b1;
        exp_d     = $signed({2'b00, a_q.exp}) - $signed({2'b00, b_q.exp}) + 10'(BIAS);
        cnt_d     = '0;
        state_d   = ST_DIV;
      end
      ST_DIV: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(QW - 1)) state_d = ST_NORM;
      end
      ST_NORM: begin
        result_d = norm_result;
        ovf_d    = norm_ovf;
        unf_d    = norm_unf;
        dbz_d    = norm_dbz;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      exp_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      exp_q    <= exp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_seq_div.sv
// Scoreboard bench for fp_seq_div: expected results queued at start, checked at done.
module tb_fp_seq_div;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic        busy, done, overflow, underflow, div_by_zero;
  logic [31:0] result;

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_OV   = 3'b100;
  localparam logic [2:0] F_UN   = 3'b010;
  localparam logic [2:0] F_DZ   = 3'b001;

`ifdef FP_DIV_ROUND_EN
  localparam logic [31:0] THIRD = 32'h3EAA_AAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAA_AAAA;
`endif

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;

  fp_seq_div dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .overflow    (overflow),
    .underflow   (underflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] rv, input logic [2:0] fv);
    exp_t e;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    start_cyc = cyc + 1;
    e.res = rv;
    e.flg = fv;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit   seen = 1'b0;
    exp_t e;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, "_latency"}, 32'(cyc - start_cyc), 32'd28);
    check({tag, "_result"}, result, e.res);
    check({tag, "_flags"}, 32'({overflow, underflow, div_by_zero}), 32'(e.flg));
    check({tag, "_busy_with_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_result_hold"}, result, e.res);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_flags"}, 32'({overflow, underflow, div_by_zero}), 32'd0);
  endtask

  initial begin
    int extra;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE); wait_done("six_div_two");
    issue(32'h3F80_0000, 32'h4040_0000, THIRD,         F_NONE); wait_done("one_third");
    issue(32'hC100_0000, 32'h3F00_0000, 32'hC180_0000, F_NONE); wait_done("neg_eight_half");
    issue(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, F_DZ);   wait_done("one_div_zero");
    issue(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, F_DZ);   wait_done("neg_div_zero");
    issue(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, F_DZ);   wait_done("zero_zero");
    issue(32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000, F_DZ);   wait_done("negzero_zero");
    issue(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, F_OV);   wait_done("overflow");
    issue(32'hFF00_0000, 32'h0080_0000, 32'hFF80_0000, F_OV);   wait_done("neg_overflow");
    issue(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, F_UN);   wait_done("underflow");
    issue(32'h0000_0000, 32'h7F00_0000, 32'h0000_0000, F_NONE); wait_done("zero_over_unf");
    issue(32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, F_NONE); wait_done("neg_zero_div");
    issue(32'h4040_0000, 32'h3FC0_0000, 32'h4000_0000, F_NONE); wait_done("three_div_1p5");

    // Second start while busy must be ignored.
    issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE);
    repeat (4) @(negedge clk);
    a = 32'h3F80_0000;
    b = 32'h4040_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored_start");
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("single_done", 32'(extra), 32'd0);

    // Reset mid-operation drops the job.
    issue(32'hC100_0000, 32'h3F00_0000, 32'hC180_0000, F_NONE);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("mid_reset");
    rst = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("no_done_after_reset", 32'(extra), 32'd0);
    issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE); wait_done("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
